hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline. Sits beside the ID stage.
- Keeps the existing load-use and jump-register stall rules, and adds a configurable branch-in-ID mode.
- Adds a register scoreboard plus a small FSM tracking one in-flight multi-cycle MDU (mul/div) op, raising RAW/WAW and structural stalls.
- Provides a saturating stall-cycle counter for performance measurement.

Parameters:
- ADDR_W, 5, register address width; the scoreboard has 2**ADDR_W entries.
- LAT_W, 4, width of the MDU latency field; maximum latency is 2**LAT_W-1 cycles.
- BRANCH_IN_ID, 1, when 1 a taken conditional branch resolved in ID gets the same operand hazard rules as JR.
- PC_J, 3'b001, pc_src code for J/JAL.
- PC_JR, 3'b010, pc_src code for JR/JALR.
- PERF_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exc_or_int  in  1  exception/interrupt redirect this cycle.
- pc_src  in  3  next-PC select from the ID control unit.
- id_branch_taken  in  1  conditional branch in ID evaluates taken.
- id_rs_addr, id_rt_addr  in  ADDR_W each  ID source registers.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads that source.
- id_reg_write  in  1  the ID instruction writes a register.
- id_write_addr  in  ADDR_W  its destination.
- id_is_mdu  in  1  the ID instruction is an MDU op.
- ex_reg_write, ex_mem_read  in  1 each  ID/EX control bits.
- ex_write_addr  in  ADDR_W  ID/EX destination.
- mem_mem_read  in  1  EX/MEM load flag.
- mem_write_addr  in  ADDR_W  EX/MEM destination.
- mdu_start  in  1  an MDU op is in EX this cycle.
- mdu_dest  in  ADDR_W  its destination.
- mdu_lat  in  LAT_W  its latency in cycles.
- data_hazard  out  1  stall IF/ID and bubble ID/EX.
- jump_hazard  out  1  flush IF/ID.
- mdu_busy  out  1  FSM is not IDLE.
- mdu_wb  out  1  one-cycle pulse: write back the MDU result this cycle.
- mdu_wb_addr  out  ADDR_W  writeback destination.
- pending  out  2**ADDR_W  scoreboard bit vector.
- stall_count  out  PERF_W  saturating count of data_hazard cycles.

Behaviour:
- Reset values: FSM=IDLE, pending=0, count=0, mdu_wb_addr=0, stall_count=0.
- Reset outputs: data_hazard=0, jump_hazard=0, mdu_busy=0, mdu_wb=0.
- Reset mid-MDU-op: the op is abandoned and all state above is restored.
- Register 0 is never hazardous: a match on address 0 is ignored, and pending[0] stays 0.
- "last" means ex_write_addr matches any used ID source. "second" means mem_write_addr matches any used ID source. A source counts only if its id_uses_* bit is set.
- lw = ex_mem_read & last.
- jr = (pc_src==PC_JR, or BRANCH_IN_ID & id_branch_taken) & ((ex_reg_write & last) | (mem_mem_read & second)).
- sb_raw: an ID source is used and its pending bit is set, excluding mdu_wb_addr while in the WB state. The register file writes before it reads, so no stall is needed that cycle.
- sb_waw = id_reg_write & pending[id_write_addr], with the same WB exclusion.
- struct = id_is_mdu & state==BUSY.
- data_hazard = lw | jr | sb_raw | sb_waw | struct. This output is combinational.
- jump_hazard = exc_or_int | pc_src==PC_J | (~data_hazard & (pc_src==PC_JR | (BRANCH_IN_ID & id_branch_taken))).
- FSM states:
  - IDLE: on start = mdu_start & ~exc_or_int, load count=max(mdu_lat,1), latch mdu_wb_addr=mdu_dest, set pending[mdu_dest] when mdu_dest≠0, and go to BUSY.
  - BUSY: count decrements by 1 each cycle. When count==1, go to WB next. mdu_start while BUSY cannot legally occur because struct prevents it; if it does occur it is ignored.
  - WB: mdu_wb=1 for exactly one cycle, and pending[mdu_wb_addr] clears at the edge. On start in the same cycle, go directly to BUSY with the new op; if the new op has the same dest, its set takes priority over the clear. Otherwise go to IDLE.
- Latency: with mdu_lat=N, mdu_wb asserts N+1 cycles after the mdu_start cycle. mdu_lat=0 is treated as 1.
- exc_or_int during BUSY/WB does not cancel the op; it has already passed EX and is committed.
- stall_count increments each cycle data_hazard=1 and saturates at all-ones.

Decomposition:
- Shared package cpu_pkg holds:
  - the pc_src code constants PC_J and PC_JR;
  - the MDU FSM state encoding {IDLE=2'd0, BUSY=2'd1, WB=2'd2}.
- One sub-module, mdu_tracker: the FSM, counter and pending vector.
- The hazard equations and the perf counter stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_addr=8, id_rs_addr=8, id_uses_rs=1 -> data_hazard=1 for one cycle, jump_hazard=0. Repeat with id_uses_rs=0 -> data_hazard=0.
- JR after load, two back: pc_src=PC_JR, mem_mem_read=1, mem_write_addr=31, id_rs_addr=31 -> data_hazard=1 and jump_hazard=0 for that cycle. Next cycle with no match -> jump_hazard=1.
- MDU issue: mdu_start, mdu_dest=9, mdu_lat=3 at cycle T -> pending[9]=1 from T+1. ID reading r9 stalls through T+3. mdu_wb=1 only at T+4 with no stall. pending[9]=0 at T+5.
- Structural/back-to-back: id_is_mdu during BUSY -> data_hazard=1. mdu_start in the WB cycle with the same dest=9 -> pending[9] stays 1 and state returns to BUSY.
- Exception: mdu_start together with exc_or_int -> no state change and jump_hazard=1. exc_or_int mid-BUSY -> mdu_wb still pulses on schedule. Reset mid-BUSY -> all outputs 0 on the next cycle.
- Counter: hold the load-use condition for 2**PERF_W+5 cycles (PERF_W=4 build) -> stall_count=15 and holds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: next-PC select codes and MDU tracker state encoding.
package cpu_pkg;

   localparam logic [2:0] PC_J  = 3'b001;
   localparam logic [2:0] PC_JR = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      WB   = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_tracker.sv
// Tracks one in-flight multi-cycle MDU op: latency countdown, writeback pulse
// and the per-register pending scoreboard.
module mdu_tracker
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned LAT_W  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      mdu_dest,
   input  logic [LAT_W-1:0]       mdu_lat,
   output mdu_state_e             state,
   output logic                   mdu_busy,
   output logic                   mdu_wb,
   output logic [ADDR_W-1:0]      mdu_wb_addr,
   output logic [2**ADDR_W-1:0]   pending
);

   localparam int unsigned NREG = 2**ADDR_W;

   mdu_state_e        state_q, state_d;
   logic [LAT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [NREG-1:0]   pend_q, pend_d;
   logic              load;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         wb_addr_q <= '0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wb_addr_q <= wb_addr_d;
         pend_q    <= pend_d;
      end
   end

   // Next state; a new op loaded in WB overrides the clear of the retiring dest
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wb_addr_d = wb_addr_q;
      pend_d    = pend_q;
      load      = 1'b0;
      unique case (state_q)
         IDLE: load = start;
         BUSY: begin
            count_d = count_q - LAT_W'(1);
            if (count_q == LAT_W'(1)) state_d = WB;
         end
         WB: begin
            pend_d[wb_addr_q] = 1'b0;
            state_d           = IDLE;
            load              = start;
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d   = BUSY;
         count_d   = (mdu_lat == '0) ? LAT_W'(1) : mdu_lat;
         wb_addr_d = mdu_dest;
         if (mdu_dest != '0) pend_d[mdu_dest] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   assign state       = state_q;
   assign mdu_busy    = (state_q != IDLE);
   assign mdu_wb      = (state_q == WB);
   assign mdu_wb_addr = wb_addr_q;
   assign pending     = pend_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use / jump-register / branch-in-ID stalls,
// MDU scoreboard RAW/WAW/structural stalls and a saturating stall counter.
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W       = 5,
   parameter int unsigned LAT_W        = 4,
   parameter bit          BRANCH_IN_ID = 1'b1,
   parameter logic [2:0]  PC_J         = cpu_pkg::PC_J,
   parameter logic [2:0]  PC_JR        = cpu_pkg::PC_JR,
   parameter int unsigned PERF_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 exc_or_int,
   input  logic [2:0]           pc_src,
   input  logic                 id_branch_taken,
   input  logic [ADDR_W-1:0]    id_rs_addr,
   input  logic [ADDR_W-1:0]    id_rt_addr,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 id_reg_write,
   input  logic [ADDR_W-1:0]    id_write_addr,
   input  logic                 id_is_mdu,
   input  logic                 ex_reg_write,
   input  logic                 ex_mem_read,
   input  logic [ADDR_W-1:0]    ex_write_addr,
   input  logic                 mem_mem_read,
   input  logic [ADDR_W-1:0]    mem_write_addr,
   input  logic                 mdu_start,
   input  logic [ADDR_W-1:0]    mdu_dest,
   input  logic [LAT_W-1:0]     mdu_lat,
   output logic                 data_hazard,
   output logic                 jump_hazard,
   output logic                 mdu_busy,
   output logic                 mdu_wb,
   output logic [ADDR_W-1:0]    mdu_wb_addr,
   output logic [2**ADDR_W-1:0] pending,
   output logic [PERF_W-1:0]    stall_count
);

   mdu_state_e state;
   logic rs_ok, rt_ok, last, second, in_wb, jr_sel;
   logic lw_haz, jr_haz, raw_haz, waw_haz, struct_haz;

   mdu_tracker #(.ADDR_W(ADDR_W), .LAT_W(LAT_W)) u_mdu (
      .clk         (clk),
      .reset       (reset),
      .start       (mdu_start & ~exc_or_int),
      .mdu_dest    (mdu_dest),
      .mdu_lat     (mdu_lat),
      .state       (state),
      .mdu_busy    (mdu_busy),
      .mdu_wb      (mdu_wb),
      .mdu_wb_addr (mdu_wb_addr),
      .pending     (pending)
   );

   // r0 is never a hazard source
   assign rs_ok  = id_uses_rs & (id_rs_addr != '0);
   assign rt_ok  = id_uses_rt & (id_rt_addr != '0);
   assign last   = (rs_ok & (id_rs_addr == ex_write_addr))  | (rt_ok & (id_rt_addr == ex_write_addr));
   assign second = (rs_ok & (id_rs_addr == mem_write_addr)) | (rt_ok & (id_rt_addr == mem_write_addr));
   assign in_wb  = (state == WB);
   assign jr_sel = (pc_src == PC_JR) | (BRANCH_IN_ID & id_branch_taken);

   // The register file writes before it reads, so the retiring MDU dest is already safe
   assign raw_haz = (rs_ok & pending[id_rs_addr] & ~(in_wb & (id_rs_addr == mdu_wb_addr)))
                  | (rt_ok & pending[id_rt_addr] & ~(in_wb & (id_rt_addr == mdu_wb_addr)));
   assign waw_haz = id_reg_write & pending[id_write_addr] & ~(in_wb & (id_write_addr == mdu_wb_addr));

   assign lw_haz      = ex_mem_read & last;
   assign jr_haz      = jr_sel & ((ex_reg_write & last) | (mem_mem_read & second));
   assign struct_haz  = id_is_mdu & (state == BUSY);
   assign data_hazard = lw_haz | jr_haz | raw_haz | waw_haz | struct_haz;
   assign jump_hazard = exc_or_int | (pc_src == PC_J) | (~data_hazard & jr_sel);

   // Saturating performance counter of stall cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (data_hazard && (stall_count != '1)) begin
         stall_count <= stall_count + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: cycle-level reference model feeds an
// expectation queue that is drained against the DUT at each falling edge.
module tb_hazard_scoreboard;
   import cpu_pkg::*;

   localparam int unsigned AW = 5;
   localparam int unsigned LW = 4;
   localparam int unsigned PW = 4;
   localparam int unsigned NR = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, exc_or_int, id_branch_taken, id_uses_rs, id_uses_rt;
   logic          id_reg_write, id_is_mdu, ex_reg_write, ex_mem_read, mem_mem_read, mdu_start;
   logic [2:0]    pc_src;
   logic [AW-1:0] id_rs_addr, id_rt_addr, id_write_addr, ex_write_addr, mem_write_addr, mdu_dest;
   logic [LW-1:0] mdu_lat;
   logic          data_hazard, jump_hazard, mdu_busy, mdu_wb;
   logic [AW-1:0] mdu_wb_addr;
   logic [NR-1:0] pending;
   logic [PW-1:0] stall_count;

   hazard_scoreboard #(.ADDR_W(AW), .LAT_W(LW), .BRANCH_IN_ID(1'b1), .PERF_W(PW)) dut (
      .clk(clk), .reset(reset), .exc_or_int(exc_or_int), .pc_src(pc_src),
      .id_branch_taken(id_branch_taken), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
      .id_write_addr(id_write_addr), .id_is_mdu(id_is_mdu), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr), .mem_mem_read(mem_mem_read),
      .mem_write_addr(mem_write_addr), .mdu_start(mdu_start), .mdu_dest(mdu_dest),
      .mdu_lat(mdu_lat), .data_hazard(data_hazard), .jump_hazard(jump_hazard),
      .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_wb_addr(mdu_wb_addr), .pending(pending),
      .stall_count(stall_count)
   );

   typedef struct {
      logic          dh, jh, busy, wb;
      logic [AW-1:0] wba;
      logic [NR-1:0] pend;
      logic [PW-1:0] stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: an op in flight is described by the absolute cycle of its writeback
   int            cyc = 0;
   bit            act = 1'b0;
   int            wb_cyc = 0;
   logic [AW-1:0] m_wba = '0;
   logic [NR-1:0] m_pend = '0;
   int            m_stall = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit src_hit(input logic use_b, input logic [AW-1:0] a, input logic [AW-1:0] w);
      return use_b && (a != 0) && (a == w);
   endfunction

   function automatic bit pend_hit(input logic use_b, input logic [AW-1:0] a, input bit wb_now);
      return use_b && (a != 0) && m_pend[a] && !(wb_now && a == m_wba);
   endfunction

   function automatic exp_t predict();
      exp_t e;
      bit wb_now, busy_now, l, s, jsel, lw, jr, raw, waw, st;
      wb_now   = act && (cyc == wb_cyc);
      busy_now = act && (cyc < wb_cyc);
      l    = src_hit(id_uses_rs, id_rs_addr, ex_write_addr)  || src_hit(id_uses_rt, id_rt_addr, ex_write_addr);
      s    = src_hit(id_uses_rs, id_rs_addr, mem_write_addr) || src_hit(id_uses_rt, id_rt_addr, mem_write_addr);
      jsel = (pc_src == 3'b010) || id_branch_taken;
      lw   = ex_mem_read && l;
      jr   = jsel && ((ex_reg_write && l) || (mem_mem_read && s));
      raw  = pend_hit(id_uses_rs, id_rs_addr, wb_now) || pend_hit(id_uses_rt, id_rt_addr, wb_now);
      waw  = pend_hit(id_reg_write, id_write_addr, wb_now);
      st   = id_is_mdu && busy_now;
      e.dh    = lw || jr || raw || waw || st;
      e.jh    = exc_or_int || (pc_src == 3'b001) || (!e.dh && jsel);
      e.busy  = act;
      e.wb    = wb_now;
      e.wba   = m_wba;
      e.pend  = m_pend;
      e.stall = PW'(m_stall);
      return e;
   endfunction

   task automatic model_edge(input bit dh);
      bit wb_now, accept;
      int lat;
      if (reset) begin
         act = 1'b0; m_pend = '0; m_wba = '0; m_stall = 0;
      end else begin
         wb_now = act && (cyc == wb_cyc);
         accept = mdu_start && !exc_or_int && (!act || wb_now);
         if (wb_now) begin
            m_pend[m_wba] = 1'b0;
            act = 1'b0;
         end
         if (accept) begin
            lat    = (mdu_lat == 0) ? 1 : int'(mdu_lat);
            act    = 1'b1;
            wb_cyc = cyc + lat + 1;
            m_wba  = mdu_dest;
            if (mdu_dest != 0) m_pend[mdu_dest] = 1'b1;
         end
         if (dh && m_stall < (2**PW - 1)) m_stall++;
      end
      cyc++;
   endtask

   // One clock: queue the expectation, compare at the falling edge, advance the model
   task automatic step();
      exp_t e, g;
      e = predict();
      exp_q.push_back(e);
      @(negedge clk);
      g = exp_q.pop_front();
      check("data_hazard", 64'(data_hazard), 64'(g.dh));
      check("jump_hazard", 64'(jump_hazard), 64'(g.jh));
      check("mdu_busy",    64'(mdu_busy),    64'(g.busy));
      check("mdu_wb",      64'(mdu_wb),      64'(g.wb));
      check("mdu_wb_addr", 64'(mdu_wb_addr), 64'(g.wba));
      check("pending",     64'(pending),     64'(g.pend));
      check("stall_count", 64'(stall_count), 64'(g.stall));
      @(posedge clk);
      model_edge(e.dh);
      #1;
   endtask

   task automatic idle();
      exc_or_int = 0; pc_src = 3'b000; id_branch_taken = 0;
      id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_reg_write = 0; id_write_addr = 0; id_is_mdu = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_write_addr = 0;
      mem_mem_read = 0; mem_write_addr = 0;
      mdu_start = 0; mdu_dest = 0; mdu_lat = 0;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd8;
         2: return 5'd9;
         default: return 5'd31;
      endcase
   endfunction

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      step();
      step();
      reset = 1'b0;
      step();

      // Load-use, then the same with the source unused
      ex_mem_read = 1; ex_write_addr = 8; id_rs_addr = 8; id_uses_rs = 1;
      #1 check("lu_dh", 64'(data_hazard), 64'd1);
      check("lu_jh", 64'(jump_hazard), 64'd0);
      step();
      id_uses_rs = 0;
      #1 check("lu_unused_dh", 64'(data_hazard), 64'd0);
      step();
      idle();

      // JR after a load two instructions back
      pc_src = PC_JR; mem_mem_read = 1; mem_write_addr = 31; id_rs_addr = 31; id_uses_rs = 1;
      #1 check("jr_dh", 64'(data_hazard), 64'd1);
      check("jr_jh", 64'(jump_hazard), 64'd0);
      step();
      mem_mem_read = 0; mem_write_addr = 0;
      #1 check("jr_go_jh", 64'(jump_hazard), 64'd1);
      step();
      idle();
      step();

      // MDU issue r9, latency 3; reader of r9 stalls until the writeback cycle
      mdu_start = 1; mdu_dest = 9; mdu_lat = 3;
      step();
      idle(); id_rs_addr = 9; id_uses_rs = 1;
      #1 check("mdu_pend9", 64'(pending[9]), 64'd1);
      step();
      step();
      id_is_mdu = 1;
      #1 check("struct_dh", 64'(data_hazard), 64'd1);
      step();
      id_is_mdu = 0;
      #1 check("mdu_wb_T4", 64'(mdu_wb), 64'd1);
      check("wb_nostall", 64'(data_hazard), 64'd0);
      step();
      #1 check("mdu_pend9_clr", 64'(pending[9]), 64'd0);
      step();
      idle();

      // Back-to-back on the same destination through the WB cycle
      mdu_start = 1; mdu_dest = 9; mdu_lat = 0;
      step();
      idle();
      step();
      mdu_start = 1; mdu_dest = 9; mdu_lat = 2;
      #1 check("b2b_wb", 64'(mdu_wb), 64'd1);
      step();
      idle();
      #1 check("b2b_pend9", 64'(pending[9]), 64'd1);
      check("b2b_busy", 64'(mdu_busy), 64'd1);
      repeat (4) step();

      // Start qualified by exception; exception mid-op does not cancel
      mdu_start = 1; mdu_dest = 5; mdu_lat = 4; exc_or_int = 1;
      #1 check("exc_jh", 64'(jump_hazard), 64'd1);
      step();
      exc_or_int = 0;
      #1 check("exc_nostart", 64'(mdu_busy), 64'd0);
      step();
      idle();
      step();
      exc_or_int = 1;
      step();
      exc_or_int = 0;
      step(); step();
      #1 check("exc_wb_sched", 64'(mdu_wb), 64'd1);
      step();
      step();

      // Reset in the middle of an op
      mdu_start = 1; mdu_dest = 7; mdu_lat = 5;
      step();
      idle();
      step();
      reset = 1;
      step();
      reset = 0;
      #1 check("rst_busy", 64'(mdu_busy), 64'd0);
      check("rst_pend", 64'(pending), 64'd0);
      check("rst_dh", 64'(data_hazard), 64'd0);
      check("rst_stall", 64'(stall_count), 64'd0);
      step();

      // Stall counter saturation
      ex_mem_read = 1; ex_write_addr = 8; id_rs_addr = 8; id_uses_rs = 1;
      repeat (2**PW + 5) step();
      #1 check("stall_sat", 64'(stall_count), 64'd15);
      step();
      idle();
      step();

      // Random traffic over a small register set to force collisions
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 63) == 0);
         exc_or_int      = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: pc_src = 3'b000;
            1: pc_src = PC_J;
            2: pc_src = PC_JR;
            default: pc_src = 3'b100;
         endcase
         id_branch_taken = ($urandom_range(0, 5) == 0);
         id_rs_addr      = rnd_addr();
         id_rt_addr      = rnd_addr();
         id_uses_rs      = 1'($urandom_range(0, 1));
         id_uses_rt      = 1'($urandom_range(0, 1));
         id_reg_write    = 1'($urandom_range(0, 1));
         id_write_addr   = rnd_addr();
         id_is_mdu       = ($urandom_range(0, 3) == 0);
         ex_reg_write    = 1'($urandom_range(0, 1));
         ex_mem_read     = ($urandom_range(0, 3) == 0);
         ex_write_addr   = rnd_addr();
         mem_mem_read    = ($urandom_range(0, 3) == 0);
         mem_write_addr  = rnd_addr();
         mdu_start       = ($urandom_range(0, 3) == 0);
         mdu_dest        = rnd_addr();
         mdu_lat         = LW'($urandom_range(0, 5));
         step();
      end
      reset = 0;
      idle();
      step();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
